// File: rtl/router_pkg.sv
// Shared definitions for the router ingress controller: default sizing and the
// 3-bit binary state encoding (DECODE_ADDRESS must stay at zero).
package router_pkg;

  localparam int NUM_PORTS_DEF = 3;
  localparam int ADDR_W_DEF    = 2;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_AFTER_FULL    = 3'd3,
    LOAD_PARITY        = 3'd4,
    FIFO_FULL_STATE    = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } router_state_t;

endpackage

// File: rtl/router_fsm.sv
// Packet-ingress controller: latches the destination port, waits for that FIFO to
// drain, then sequences header/payload/parity writes with full-stall recovery.
import router_pkg::*;

module router_fsm #(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pkt_valid,
  input  logic [ADDR_W-1:0]    data_in,
  input  logic                 parity_done,
  input  logic                 low_pkt_valid,
  input  logic                 fifo_full,
  input  logic [NUM_PORTS-1:0] fifo_empty,
  input  logic [NUM_PORTS-1:0] soft_reset,
  output logic [ADDR_W-1:0]    dest,
  output logic                 detect_add,
  output logic                 lfd_state,
  output logic                 ld_state,
  output logic                 laf_state,
  output logic                 full_state,
  output logic                 rst_int_reg,
  output logic                 write_enb_reg,
  output logic                 busy,
  output logic [2:0]           state_o
);

  localparam logic [ADDR_W:0] NUM_PORTS_W = NUM_PORTS[ADDR_W:0];

  router_state_t     state_q, state_d;
  logic [ADDR_W-1:0] dest_q, dest_d;

  logic addr_ok;
  logic in_empty;
  logic dest_empty;
  logic dest_soft_rst;

  // Guard every per-port lookup so an out-of-range address never reads past the vector.
  assign addr_ok       = ({1'b0, data_in} < NUM_PORTS_W);
  assign in_empty      = addr_ok ? fifo_empty[data_in] : 1'b0;
  assign dest_empty    = ({1'b0, dest_q} < NUM_PORTS_W) ? fifo_empty[dest_q] : 1'b0;
  assign dest_soft_rst = ({1'b0, dest_q} < NUM_PORTS_W) ? soft_reset[dest_q] : 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DECODE_ADDRESS;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    if (state_q == DECODE_ADDRESS && pkt_valid && addr_ok) begin
      dest_d = data_in;
    end
    if (state_q != DECODE_ADDRESS && dest_soft_rst) begin
      state_d = DECODE_ADDRESS;
    end else begin
      case (state_q)
        DECODE_ADDRESS: begin
          if (pkt_valid && addr_ok) begin
            state_d = in_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
          end
        end
        WAIT_TILL_EMPTY:    if (dest_empty) state_d = LOAD_FIRST_DATA;
        LOAD_FIRST_DATA:    state_d = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full)       state_d = FIFO_FULL_STATE;
          else if (!pkt_valid) state_d = LOAD_PARITY;
        end
        FIFO_FULL_STATE:    if (!fifo_full) state_d = LOAD_AFTER_FULL;
        LOAD_AFTER_FULL: begin
          if (parity_done)        state_d = DECODE_ADDRESS;
          else if (low_pkt_valid) state_d = LOAD_PARITY;
          else                    state_d = LOAD_DATA;
        end
        LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        default:            state_d = DECODE_ADDRESS;
      endcase
    end
  end

  // Moore outputs: decoded from the registered state only.
  always_comb begin
    detect_add    = (state_q == DECODE_ADDRESS);
    lfd_state     = (state_q == LOAD_FIRST_DATA);
    ld_state      = (state_q == LOAD_DATA);
    laf_state     = (state_q == LOAD_AFTER_FULL);
    full_state    = (state_q == FIFO_FULL_STATE);
    rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                    (state_q == LOAD_AFTER_FULL);
    busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));
  end

  assign dest    = dest_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm: each scenario task steps the clock and checks the
// decoded output vector and latched destination against hand-derived constants.
module tb_router_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] soft_reset;
  logic [1:0] dest;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       rst_int_reg, write_enb_reg, busy;
  logic [2:0] state_o;

  int tests_run = 0;
  int tests_failed = 0;

  // {detect_add, lfd, ld, laf, full, rst_int, write_enb, busy}
  localparam logic [7:0] O_DA  = 8'h80;
  localparam logic [7:0] O_LFD = 8'h41;
  localparam logic [7:0] O_LD  = 8'h22;
  localparam logic [7:0] O_LAF = 8'h13;
  localparam logic [7:0] O_FFS = 8'h09;
  localparam logic [7:0] O_LP  = 8'h03;
  localparam logic [7:0] O_CPE = 8'h05;
  localparam logic [7:0] O_WTE = 8'h01;

  logic [7:0] outs;
  assign outs = {detect_add, lfd_state, ld_state, laf_state, full_state,
                 rst_int_reg, write_enb_reg, busy};

  router_fsm dut (
    .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .soft_reset(soft_reset), .dest(dest),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .write_enb_reg(write_enb_reg), .busy(busy), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; pkt_valid = 1'b0; data_in = 2'd0; parity_done = 1'b0;
    low_pkt_valid = 1'b0; fifo_full = 1'b0; fifo_empty = 3'b111; soft_reset = 3'b000;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1; pkt_valid = 1'b1; data_in = 2'd1;
    step(); step();
    tests_run++;
    if (outs !== O_DA) begin
      tests_failed++; $display("FAIL reset_outs got=%h exp=%h", outs, O_DA);
    end
    tests_run++;
    if (dest !== 2'd0 || state_o !== 3'd0) begin
      tests_failed++; $display("FAIL reset_dest_state got=%0d/%0d exp=0/0", dest, state_o);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_normal();
    logic [7:0] exp_seq [7] = '{O_LFD, O_LD, O_LD, O_LD, O_LP, O_CPE, O_DA};
    idle_inputs();
    pkt_valid = 1'b1; data_in = 2'd2;
    for (int i = 0; i < 7; i++) begin
      if (i == 4) pkt_valid = 1'b0;
      step();
      tests_run++;
      if (outs !== exp_seq[i]) begin
        tests_failed++; $display("FAIL normal_step%0d got=%h exp=%h", i, outs, exp_seq[i]);
      end
    end
    tests_run++;
    if (dest !== 2'd2) begin
      tests_failed++; $display("FAIL normal_dest got=%0d exp=2", dest);
    end
  endtask

  task automatic test_wait_empty();
    idle_inputs();
    fifo_empty = 3'b110; pkt_valid = 1'b1; data_in = 2'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (outs !== O_WTE) begin
        tests_failed++; $display("FAIL wait_hold%0d got=%h exp=%h", i, outs, O_WTE);
      end
    end
    fifo_empty = 3'b111;
    step();
    tests_run++;
    if (outs !== O_LFD || dest !== 2'd0) begin
      tests_failed++; $display("FAIL wait_release got=%h/%0d exp=%h/0", outs, dest, O_LFD);
    end
    pkt_valid = 1'b0;
    step(); step(); step(); step();
    tests_run++;
    if (outs !== O_DA) begin
      tests_failed++; $display("FAIL wait_done got=%h exp=%h", outs, O_DA);
    end
  endtask

  task automatic test_full_stall();
    idle_inputs();
    pkt_valid = 1'b1; data_in = 2'd1;
    step(); step();
    tests_run++;
    if (outs !== O_LD) begin
      tests_failed++; $display("FAIL full_pre got=%h exp=%h", outs, O_LD);
    end
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (outs !== O_FFS) begin
        tests_failed++; $display("FAIL full_hold%0d got=%h exp=%h", i, outs, O_FFS);
      end
    end
    fifo_full = 1'b0;
    step();
    tests_run++;
    if (outs !== O_LAF) begin
      tests_failed++; $display("FAIL full_laf got=%h exp=%h", outs, O_LAF);
    end
    low_pkt_valid = 1'b1; pkt_valid = 1'b0;
    step();
    tests_run++;
    if (outs !== O_LP) begin
      tests_failed++; $display("FAIL full_low_pkt got=%h exp=%h", outs, O_LP);
    end
    low_pkt_valid = 1'b0;
    step();
    tests_run++;
    if (outs !== O_CPE) begin
      tests_failed++; $display("FAIL full_cpe got=%h exp=%h", outs, O_CPE);
    end
    fifo_full = 1'b1;
    step();
    tests_run++;
    if (outs !== O_FFS) begin
      tests_failed++; $display("FAIL cpe_to_full got=%h exp=%h", outs, O_FFS);
    end
    fifo_full = 1'b0;
    step();
    parity_done = 1'b1;
    step();
    tests_run++;
    if (outs !== O_DA) begin
      tests_failed++; $display("FAIL laf_parity_done got=%h exp=%h", outs, O_DA);
    end
    idle_inputs();
  endtask

  task automatic test_laf_to_ld();
    idle_inputs();
    pkt_valid = 1'b1; data_in = 2'd0;
    step(); step();
    fifo_full = 1'b1; step();
    fifo_full = 1'b0; step();
    step();
    tests_run++;
    if (outs !== O_LD) begin
      tests_failed++; $display("FAIL laf_to_ld got=%h exp=%h", outs, O_LD);
    end
    pkt_valid = 1'b0;
    step(); step(); step();
    tests_run++;
    if (outs !== O_DA) begin
      tests_failed++; $display("FAIL laf_to_ld_done got=%h exp=%h", outs, O_DA);
    end
  endtask

  task automatic test_soft_reset();
    idle_inputs();
    pkt_valid = 1'b1; data_in = 2'd1;
    step(); step();
    soft_reset = 3'b010;
    step();
    tests_run++;
    if (outs !== O_DA || dest !== 2'd1) begin
      tests_failed++; $display("FAIL soft_rst_sel got=%h/%0d exp=%h/1", outs, dest, O_DA);
    end
    // Same pulse while already decoding must not block a new packet.
    step();
    tests_run++;
    if (outs !== O_LFD) begin
      tests_failed++; $display("FAIL soft_rst_in_da got=%h exp=%h", outs, O_LFD);
    end
    soft_reset = 3'b000;
    step();
    soft_reset = 3'b100;
    step();
    tests_run++;
    if (outs !== O_LD) begin
      tests_failed++; $display("FAIL soft_rst_other got=%h exp=%h", outs, O_LD);
    end
    soft_reset = 3'b000; pkt_valid = 1'b0;
    step(); step(); step();
    tests_run++;
    if (outs !== O_DA) begin
      tests_failed++; $display("FAIL soft_rst_done got=%h exp=%h", outs, O_DA);
    end
  endtask

  task automatic test_bad_address();
    idle_inputs();
    pkt_valid = 1'b1; data_in = 2'd3;
    for (int i = 0; i < 5; i++) begin
      step();
      tests_run++;
      if (outs !== O_DA) begin
        tests_failed++; $display("FAIL bad_addr%0d got=%h exp=%h", i, outs, O_DA);
      end
    end
    tests_run++;
    if (dest !== 2'd1) begin
      tests_failed++; $display("FAIL bad_addr_dest got=%0d exp=1", dest);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_packet();
    idle_inputs();
    pkt_valid = 1'b1; data_in = 2'd2;
    step(); step();
    reset = 1'b1;
    step();
    tests_run++;
    if (outs !== O_DA || dest !== 2'd0) begin
      tests_failed++; $display("FAIL reset_mid got=%h/%0d exp=%h/0", outs, dest, O_DA);
    end
    idle_inputs();
    step();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_normal();
    test_wait_empty();
    test_full_stall();
    test_laf_to_ld();
    test_soft_reset();
    test_bad_address();
    test_reset_mid_packet();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
